// File: rtl/enc_pkg.sv
// Shared priority-encode and popcount helpers for the event-encoder family.
package enc_pkg;

  localparam int unsigned ENC_MAX_N = 64;

  // Index of the winning set bit among the low n bits; 0 when none is set.
  function automatic int unsigned prio_index(input logic [ENC_MAX_N-1:0] vec,
                                             input int unsigned          n,
                                             input bit                   msb_first);
    int unsigned r;
    bit          found;
    r     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (vec[i]) begin
        if (msb_first || !found) r = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [ENC_MAX_N-1:0] vec);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < ENC_MAX_N; i++) c += int'(vec[i]);
    return c;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational N-to-W priority encoder with selectable direction and an any flag.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [ENC_MAX_N-1:0] wide;

  assign wide = ENC_MAX_N'(vec);
  assign idx  = W'(prio_index(wide, N, MSB_FIRST));
  assign any  = |vec;

endmodule

// File: rtl/prio_event_encoder.sv
// Sticky event capture, priority selection and valid/ready delivery of event indices.
module prio_event_encoder
  import enc_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned W        = $clog2(N),
  localparam int unsigned CW       = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          ovf_clr,
  output logic          out_valid,
  output logic [W-1:0]  out_idx,
  input  logic          out_ready,
  output logic [CW-1:0] pend_cnt,
  output logic          ovf
);

  logic [N-1:0] pend;
  logic [N-1:0] mv_mask;
  logic [W-1:0] sel;
  logic         any;
  logic         load;
  logic         move;
  logic         ovf_hit;

  prio_enc_comb #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .vec (pend),
    .idx (sel),
    .any (any)
  );

  assign load = !out_valid || out_ready;
  assign move = load && any;

  always_comb begin
    mv_mask = '0;
    if (move) mv_mask[sel] = 1'b1;
  end

  // A line being moved out this edge may re-pend without counting as overflow.
  assign ovf_hit  = |(req & pend & ~mv_mask);
  assign pend_cnt = CW'(popcount(ENC_MAX_N'(pend)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ovf       <= 1'b0;
    end else begin
      pend <= (pend & ~mv_mask) | req;
      if (load) begin
        out_valid <= any;
        if (any) out_idx <= sel;
      end
      if (ovf_hit)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Bench for prio_event_encoder: directed stimulus with a delivery-order scoreboard.
module tb_prio_event_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_m = '0;
  logic [7:0] req_l = '0;
  logic       ovf_clr = 1'b0;
  logic       out_ready = 1'b0;

  logic       valid_m, valid_l, ovf_m, ovf_l;
  logic [2:0] idx_m, idx_l;
  logic [3:0] cnt_m, cnt_l;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned q_m[$];
  int unsigned q_l[$];

  prio_event_encoder #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk), .rst (rst), .req (req_m), .ovf_clr (ovf_clr),
    .out_valid (valid_m), .out_idx (idx_m), .out_ready (out_ready),
    .pend_cnt (cnt_m), .ovf (ovf_m)
  );

  prio_event_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk), .rst (rst), .req (req_l), .ovf_clr (ovf_clr),
    .out_valid (valid_l), .out_idx (idx_l), .out_ready (out_ready),
    .pend_cnt (cnt_l), .ovf (ovf_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes resolve at the next rising edge; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_m && out_ready) begin
        if (q_m.size() == 0) check("m_extra", 32'(idx_m), 32'hFFFF_FFFF);
        else                 check("m_order", 32'(idx_m), q_m.pop_front());
      end
      if (valid_l && out_ready) begin
        if (q_l.size() == 0) check("l_extra", 32'(idx_l), 32'hFFFF_FFFF);
        else                 check("l_order", 32'(idx_l), q_l.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_valid", 32'(valid_m), 0);
    check("rst_idx",   32'(idx_m),   0);
    check("rst_cnt",   32'(cnt_m),   0);
    check("rst_ovf",   32'(ovf_m),   0);
    rst = 1'b0;
    tick();
    check("idle_valid_l", 32'(valid_l), 0);

    // single pulse, two-edge latency
    req_m = 8'h10; q_m.push_back(4);
    tick(); req_m = '0;
    check("lat1_valid", 32'(valid_m), 0);
    check("lat1_cnt",   32'(cnt_m),   1);
    tick();
    check("lat2_valid", 32'(valid_m), 1);
    check("lat2_idx",   32'(idx_m),   4);
    check("lat2_cnt",   32'(cnt_m),   0);
    out_ready = 1'b1;
    tick();
    check("drain_valid", 32'(valid_m), 0);

    // burst of all lines, full throughput
    req_m = 8'hFF;
    for (int i = 7; i >= 0; i--) q_m.push_back(i);
    tick(); req_m = '0;
    check("burst_cap_cnt", 32'(cnt_m), 8);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("burst_valid", 32'(valid_m), 1);
      check("burst_idx",   32'(idx_m),   7 - k);
      check("burst_cnt",   32'(cnt_m),   7 - k);
    end
    tick();
    check("burst_end_valid", 32'(valid_m), 0);
    check("burst_ovf",       32'(ovf_m),   0);

    // LSB-first ordering
    req_l = 8'h81; q_l.push_back(0); q_l.push_back(7);
    tick(); req_l = '0;
    tick();
    check("lsb_first", 32'(idx_l), 0);
    tick();
    check("lsb_second", 32'(idx_l), 7);
    tick();
    check("lsb_end_valid", 32'(valid_l), 0);

    // back-pressure
    out_ready = 1'b0;
    req_m = 8'h04; q_m.push_back(2); q_m.push_back(6);
    tick(); req_m = '0;
    tick();
    check("bp_offer", 32'(idx_m), 2);
    req_m = 8'h40;
    tick(); req_m = '0;
    check("bp_hold1", 32'(idx_m), 2);
    check("bp_cnt",   32'(cnt_m), 1);
    tick();
    check("bp_hold2", 32'(idx_m), 2);
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(valid_m), 1);
    check("bp_next_idx",   32'(idx_m),   6);
    check("bp_next_cnt",   32'(cnt_m),   0);
    tick();
    check("bp_end_valid", 32'(valid_m), 0);

    // overflow set / clear / clear-vs-set
    out_ready = 1'b0;
    req_m = 8'h01; q_m.push_back(0); q_m.push_back(3);
    tick(); req_m = '0;
    tick();
    req_m = 8'h08;
    tick(); req_m = '0;
    check("ovf_first", 32'(ovf_m), 0);
    req_m = 8'h08;
    tick(); req_m = '0;
    check("ovf_set", 32'(ovf_m), 1);
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_m), 0);
    req_m = 8'h08; ovf_clr = 1'b1;
    tick(); req_m = '0; ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf_m), 1);
    out_ready = 1'b1;
    tick();
    check("ovf_drain_idx", 32'(idx_m), 3);
    tick();
    check("ovf_drain_valid", 32'(valid_m), 0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    req_m = 8'h7C;
    tick(); req_m = '0;
    tick();
    check("pre_rst_valid", 32'(valid_m), 1);
    check("pre_rst_cnt",   32'(cnt_m),   4);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid_m), 0);
    check("arst_idx",   32'(idx_m),   0);
    check("arst_cnt",   32'(cnt_m),   0);
    check("arst_ovf",   32'(ovf_m),   0);
    tick();
    rst = 1'b0;
    req_m = 8'h01; q_m.push_back(0);
    tick(); req_m = '0;
    check("post_rst_lat1", 32'(valid_m), 0);
    tick();
    check("post_rst_valid", 32'(valid_m), 1);
    check("post_rst_idx",   32'(idx_m),   0);
    out_ready = 1'b1;
    tick();
    check("post_rst_end", 32'(valid_m), 0);

    tick();
    check("m_left", q_m.size(), 0);
    check("l_left", q_l.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_event_encoder.md
# prio_event_encoder

Parametrised, registered successor to the team's combinational 4-to-2 encoder. Captures single-cycle event pulses on `N` request lines into a sticky pending set, encodes the highest-priority pending line to a binary index, and delivers indices one at a time over a valid/ready handshake. It sits between interrupt/event sources and a consumer such as a sequencer or CPU port. Events are never lost silently: a repeated event on an already-pending line raises a sticky overflow flag.

## Interface
- `N`, 8: number of request lines, ≥2.
- `W`, `$clog2(N)`: index width (derived, not overridden).
- `MSB_FIRST`, 1: 1 = highest line number wins, 0 = lowest line number wins.

- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  event pulses; each high bit sampled on a rising edge is one event.
- `ovf_clr`  in  1  clears `ovf` (synchronous).
- `out_valid`  out  1  `out_idx` holds an undelivered event.
- `out_idx`  out  W  index of the event being offered.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready` at an edge.
- `pend_cnt`  out  `$clog2(N+1)`  popcount of the pending register; excludes the offered event.
- `ovf`  out  1  sticky; some event arrived on an already-pending line.

## Operation
- State:
  - `pend[N-1:0]`: pending set.
  - Output register: `out_valid`, `out_idx`.
  - `ovf`.
- Per-edge actions:
  - **Load**: occurs when `!out_valid || out_ready`.
  - **Select**: `sel` = priority-encode(`pend`) according to `MSB_FIRST`.
  - **Set**: `pend` gains `req`.
  - **Move**: on a load with `pend != 0`, `pend[sel]` is cleared and `out_idx <= sel`, `out_valid <= 1`.
  - **Load with nothing pending**: on a load with `pend == 0`, `out_valid <= 0` and `out_idx` holds its value.
  - **Set and move on the same bit**: set wins. The bit stays pending and this is a new event, not an overflow.
- Overflow: `ovf <= 1` if any `req[i]` is high while `pend[i]` is 1 and `pend[i]` is not being moved out on that edge.
  - A `req` on the line currently held in the output register is not an overflow; it simply re-pends.
  - `ovf_clr` and a new overflow on the same edge: set wins.
- Selection uses only the registered `pend`. A request never bypasses straight into the output register.
- While `out_valid && !out_ready`:
  - `out_idx` is stable.
  - Higher-priority arrivals wait in `pend`.
- `pend_cnt` is combinational from `pend`.
- Reset values: `pend=0`, `out_valid=0`, `out_idx=0`, `ovf=0`, `pend_cnt=0`.

## Timing
- Latency: `req[i]` high at edge E → `pend[i]=1` after E → `out_valid=1`, `out_idx=i` after E+1, provided the output register is empty or accepted at E+1.
- Throughput: one event per cycle with `out_ready` held high. Accept and reload happen on the same edge; no bubble while `pend != 0`.
- `out_valid` falls on the accepting edge only if `pend` is empty at that edge.
- `out_ready` is ignored while `out_valid=0`.
- Reset asserted mid-operation clears all pending and offered events immediately, asynchronously. The first edge after deassertion behaves as from idle.
- All `req` bits high at one edge: all N are delivered in priority order over N consecutive accepts. The first is offered two edges after capture.

## Structure
- Shared package `enc_pkg`:
  - `function automatic` priority encoder over a vector, with a direction argument.
  - Popcount function.
- One natural sub-module, `prio_enc_comb`: a purely combinational `N`-to-`W` priority encoder with `MSB_FIRST` and an `any` output.
  - Direct generalisation of the existing 4-to-2 encoder.
  - Reusable elsewhere.
- Top: pending register, output register, overflow flag, load control.

## Test plan
- N=8, MSB_FIRST=1, after reset: all outputs 0. One pulse `req=8'h10` → two edges later `out_valid=1`, `out_idx=4`. `out_ready=1` → `out_valid=0` next edge, `pend_cnt=0`.
- `req=8'hFF` for one cycle, `out_ready=1`: indices 7,6,5,4,3,2,1,0 on 8 consecutive edges with no gaps. `pend_cnt` steps 7→0. `ovf=0`.
- MSB_FIRST=0, `req=8'h81`: order 0 then 7.
- Back-pressure: offer idx 2 with `out_ready=0`, then pulse `req=8'h40`. `out_idx` stays 2 until accepted. Then 6 is offered, `pend_cnt=0`.
- Overflow:
  - `req=8'h08` twice before it moves out (hold `out_valid` busy with another index) → `ovf=1`.
  - `ovf_clr` → `ovf=0`.
  - `ovf_clr` coincident with a new overflow → `ovf` remains 1.
- Async reset asserted with `pend=8'h3C` and `out_valid=1` → all state 0 without a clock edge. After release, the first `req=8'h01` is delivered with normal two-edge latency.
